// File: rtl/pc_next_unit.sv
// pc_next_unit: IF-stage PC register with stall hold, pending redirect buffer,
// EX-over-ID source priority and a flush pulse on every committed redirect.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   stall               hold pc this cycle
//   sel[2:0]            001 ex_ta, 010 id_ta, 011 ex_alu, others sequential
//   ex_ta/id_ta/ex_alu  redirect targets
//   pc                  registered fetch PC
//   pc_plus             pc + INC (combinational)
//   redirect_pending    a redirect is buffered until stall drops
//   flush               one-cycle pulse when a redirect is loaded into pc
//   misalign_err        pulse when a committed target had its low bits cleared
//
// Optional: define PC_MISALIGN_CHECK_EN to force committed targets to
// word alignment and report it on misalign_err; otherwise it is tied 0.
module pc_next_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] INC      = ADDR_W'(4)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [2:0]        sel,
  input  logic [ADDR_W-1:0] ex_ta,
  input  logic [ADDR_W-1:0] id_ta,
  input  logic [ADDR_W-1:0] ex_alu,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus,
  output logic              redirect_pending,
  output logic              flush,
  output logic              misalign_err
);

  // rank: 0 none, 1 ID, 2 EX
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic [1:0]        pend_rank_q, pend_rank_d;
  logic              pend_d;
  logic [ADDR_W-1:0] pc_d;
  logic              flush_d;

  logic              req;
  logic [1:0]        live_rank;
  logic [ADDR_W-1:0] live_tgt;

  logic              commit;
  logic [ADDR_W-1:0] commit_tgt;
  logic [ADDR_W-1:0] load_tgt;

  assign pc_plus = pc + INC;

  always_comb begin
    req       = 1'b0;
    live_rank = 2'd0;
    live_tgt  = '0;
    unique case (1'b1)
      (sel == 3'b001): begin
        req       = 1'b1;
        live_rank = 2'd2;
        live_tgt  = ex_ta;
      end
      (sel == 3'b010): begin
        req       = 1'b1;
        live_rank = 2'd1;
        live_tgt  = id_ta;
      end
      (sel == 3'b011): begin
        req       = 1'b1;
        live_rank = 2'd2;
        live_tgt  = ex_alu;
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_d        = pc;
    pend_d      = redirect_pending;
    pend_tgt_d  = pend_tgt_q;
    pend_rank_d = pend_rank_q;
    flush_d     = 1'b0;
    commit      = 1'b0;
    commit_tgt  = '0;
    if (!stall) begin
      if (redirect_pending) begin
        // a strictly higher-ranked live request overrides the buffer
        commit      = 1'b1;
        pend_d      = 1'b0;
        pend_tgt_d  = '0;
        pend_rank_d = 2'd0;
        if (req && (live_rank > pend_rank_q))
          commit_tgt = live_tgt;
        else
          commit_tgt = pend_tgt_q;
      end else if (req) begin
        commit     = 1'b1;
        commit_tgt = live_tgt;
      end else begin
        pc_d = pc_plus;
      end
    end else if (req) begin
      if (!redirect_pending || (live_rank > pend_rank_q)) begin
        pend_d      = 1'b1;
        pend_tgt_d  = live_tgt;
        pend_rank_d = live_rank;
      end
    end
    if (commit) begin
      pc_d    = load_tgt;
      flush_d = 1'b1;
    end
  end

`ifdef PC_MISALIGN_CHECK_EN
  logic mis_d;

  assign load_tgt = {commit_tgt[ADDR_W-1:2], 2'b00};
  assign mis_d    = commit & (|commit_tgt[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_err <= 1'b0;
    else        misalign_err <= mis_d;
  end
`else
  assign load_tgt     = commit_tgt;
  assign misalign_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc               <= RESET_PC;
      redirect_pending <= 1'b0;
      pend_tgt_q       <= '0;
      pend_rank_q      <= 2'd0;
      flush            <= 1'b0;
    end else begin
      pc               <= pc_d;
      redirect_pending <= pend_d;
      pend_tgt_q       <= pend_tgt_d;
      pend_rank_q      <= pend_rank_d;
      flush            <= flush_d;
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: directed and random checks of pc_next_unit against
// a candidate-list reference model.
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  sel = 3'b000;
  logic [31:0] ex_ta = '0;
  logic [31:0] id_ta = '0;
  logic [31:0] ex_alu = '0;
  logic [31:0] pc;
  logic [31:0] pc_plus;
  logic        redirect_pending;
  logic        flush;
  logic        misalign_err;

  pc_next_unit dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .sel(sel),
    .ex_ta(ex_ta),
    .id_ta(id_ta),
    .ex_alu(ex_alu),
    .pc(pc),
    .pc_plus(pc_plus),
    .redirect_pending(redirect_pending),
    .flush(flush),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic [31:0] tgt;
    int          rank;
  } cand_t;

  cand_t       pq[$];
  logic [31:0] m_pc;
  bit          m_flush;
  bit          m_mis;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("pc", pc, m_pc);
    chk("pc_plus", pc_plus, m_pc + 32'd4);
    chk("flush", {31'b0, flush}, {31'b0, m_flush});
    chk("pending", {31'b0, redirect_pending},
        {31'b0, (pq.size() != 0)});
    chk("misalign", {31'b0, misalign_err}, {31'b0, m_mis});
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    pq.delete();
    m_flush = 1'b0;
    m_mis = 1'b0;
  endtask

  task automatic model_commit(logic [31:0] t);
    m_flush = 1'b1;
`ifdef PC_MISALIGN_CHECK_EN
    m_mis = (t % 4) != 0;
    m_pc = t - (t % 4);
`else
    m_pc = t;
`endif
  endtask

  // Candidates: buffered entry first, then the live request. Best is the
  // highest rank; on a tie the earlier (buffered) one wins.
  task automatic model_step();
    cand_t c[$];
    cand_t best;
    cand_t live;
    c = pq;
    if (sel == 3'd1) begin live.tgt = ex_ta; live.rank = 2; c.push_back(live); end
    if (sel == 3'd2) begin live.tgt = id_ta; live.rank = 1; c.push_back(live); end
    if (sel == 3'd3) begin live.tgt = ex_alu; live.rank = 2; c.push_back(live); end
    m_flush = 1'b0;
    m_mis = 1'b0;
    best.tgt = '0;
    best.rank = 0;
    if (c.size() > 0) begin
      best = c[0];
      foreach (c[i]) if (c[i].rank > best.rank) best = c[i];
    end
    if (!stall) begin
      pq.delete();
      if (c.size() > 0) model_commit(best.tgt);
      else m_pc = m_pc + 32'd4;
    end else if (c.size() > 0) begin
      pq.delete();
      pq.push_back(best);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    chk_all();
  endtask

  task automatic drive(logic st, logic [2:0] s, logic [31:0] a,
                       logic [31:0] b, logic [31:0] c);
    stall = st;
    sel = s;
    ex_ta = a;
    id_ta = b;
    ex_alu = c;
  endtask

  initial begin
    model_reset();
    // reset
    rst_n = 1'b0;
    step();
    step();
    chk("rst_pc", pc, 32'h0);
    rst_n = 1'b1;
    drive(0, 3'b000, 0, 0, 0);
    step();
    step();
    step();
    chk("seq_c", pc, 32'hC);
    step();
    chk("seq_10", pc, 32'h10);
    // live redirect
    drive(0, 3'b001, 32'h200, 0, 0);
    step();
    chk("live_pc", pc, 32'h200);
    chk("live_flush", {31'b0, flush}, 32'h1);
    drive(0, 3'b000, 0, 0, 0);
    step();
    chk("live_after", pc, 32'h204);
    // stalled redirect
    drive(1, 3'b010, 0, 32'h80, 0);
    step();
    drive(1, 3'b000, 0, 0, 0);
    step();
    step();
    chk("stall_hold", pc, 32'h204);
    chk("stall_pend", {31'b0, redirect_pending}, 32'h1);
    drive(0, 3'b000, 0, 0, 0);
    step();
    chk("release_pc", pc, 32'h80);
    // priority: ID pending replaced by EX
    drive(1, 3'b010, 0, 32'h80, 0);
    step();
    drive(1, 3'b011, 0, 0, 32'h300);
    step();
    drive(0, 3'b000, 0, 0, 0);
    step();
    chk("prio_id_ex", pc, 32'h300);
    // priority: EX pending kept over ID
    drive(1, 3'b011, 0, 0, 32'h300);
    step();
    drive(1, 3'b010, 0, 32'h80, 0);
    step();
    drive(0, 3'b000, 0, 0, 0);
    step();
    chk("prio_ex_id", pc, 32'h300);
    // wrap
    drive(0, 3'b001, 32'hFFFF_FFFC, 0, 0);
    step();
    drive(0, 3'b000, 0, 0, 0);
    step();
    chk("wrap", pc, 32'h0);
    // async reset with pending
    drive(1, 3'b010, 0, 32'h40, 0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all();
    chk("arst_pend", {31'b0, redirect_pending}, 32'h0);
    drive(0, 3'b000, 0, 0, 0);
    step();
    rst_n = 1'b1;
    step();
    // misaligned target
    drive(0, 3'b001, 32'h103, 0, 0);
    step();
`ifdef PC_MISALIGN_CHECK_EN
    chk("mis_pc", pc, 32'h100);
    chk("mis_err", {31'b0, misalign_err}, 32'h1);
`else
    chk("mis_pc", pc, 32'h103);
    chk("mis_err", {31'b0, misalign_err}, 32'h0);
`endif
    drive(0, 3'b000, 0, 0, 0);
    step();
    // random
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b, c;
      a = $urandom;
      b = $urandom;
      c = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        a[1:0] = 2'b00;
        b[1:0] = 2'b00;
        c[1:0] = 2'b00;
      end
      drive(($urandom_range(0, 9) < 4), 3'($urandom_range(0, 7)), a, b, c);
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Successor to the fetch-stage next-PC mux. It owns the PC register, the sequential incrementer and redirect selection.
- Adds four behaviours the mux does not have: stall-aware hold, a pending-redirect buffer for redirects that arrive during a stall, source priority, and a flush pulse.
- Sits in IF; drives instruction-memory address and IF/ID PC fields.

Parameters:
- ADDR_W, 32, PC/target width in bits.
- RESET_PC, 0, PC value loaded on reset.
- INC, 4, sequential increment added to PC.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC this cycle (hazard unit).
- sel  in  3  decision code: 001 ex_ta, 010 id_ta, 011 ex_alu, all other values sequential.
- ex_ta  in  ADDR_W  EX-stage branch target.
- id_ta  in  ADDR_W  ID-stage jump target.
- ex_alu  in  ADDR_W  EX-stage register-jump target.
- pc  out  ADDR_W  current fetch PC (registered).
- pc_plus  out  ADDR_W  pc+INC (combinational from pc).
- redirect_pending  out  1  buffered redirect waiting for stall release (registered).
- flush  out  1  one-cycle pulse when a redirect is committed to pc (registered).
- misalign_err  out  1  see Optional Feature (registered).

Behaviour:
- Reset (asynchronous, rst_n=0): pc=RESET_PC, redirect_pending=0, pending target=0, pending source=0, flush=0, misalign_err=0. Release takes effect on the first rising edge with rst_n=1.
- Arithmetic: pc_plus=(pc+INC) mod 2^ADDR_W. Wrap from all-ones region is silent, no flag.
- Redirect request this cycle: req = sel in {001,010,011}. Target is the corresponding input.
- Source rank: EX (001, 011) outranks ID (010). Between 001 and 011 only one code can be present.
- Not stalled, no pending, no req: pc<=pc_plus, flush<=0.
- Not stalled, no pending, req: pc<=selected target, flush<=1.
- Not stalled, pending set: pc<=pending target, flush<=1, redirect_pending<=0.
  - If req is also asserted the same cycle and its rank is strictly higher than the pending source, the live target is used instead. Pending is still cleared.
  - A live request of equal or lower rank is dropped.
- Stalled, req: pc holds, flush<=0.
  - If nothing is pending, latch target and rank, and set redirect_pending<=1.
  - If something is pending, replace it only when the new rank is strictly higher (EX over ID). Otherwise keep the old one.
- Stalled, no req: pc, pending and flush all hold except flush<=0.
- Latency:
  - Redirect with no stall: pc shows the target on the edge after sel is sampled.
  - Buffered redirect: pc shows the target on the first edge with stall=0.
- flush is never high two consecutive cycles unless redirects are committed on consecutive edges.
- Reset mid-stall with pending set: pending is discarded and pc=RESET_PC.

Optional Feature:
- Macro: PC_MISALIGN_CHECK_EN.
- Defined:
  - Any target committed to pc whose low 2 bits are nonzero has those bits forced to 0 before loading.
  - misalign_err pulses high for that one cycle, coincident with flush.
  - Check applies to both live and pending targets.
  - Sequential increments are never checked.
- Undefined: targets are loaded verbatim; misalign_err tied 0.

Test Plan:
- Reset: rst_n=0 for 2 cycles with RESET_PC=0x0000_0000, then release, 3 cycles with sel=000 -> pc=0x0, 0x4, 0x8, 0xC; flush=0 throughout.
- Live redirect: pc=0x10, sel=001, ex_ta=0x200 -> next pc=0x200, flush=1 one cycle, then pc=0x204.
- Stalled redirect: stall=1, sel=010, id_ta=0x80 for 1 cycle, stall held 3 cycles -> pc frozen, redirect_pending=1. When stall drops -> pc=0x80, flush=1, redirect_pending=0.
- Priority: stalled with pending ID 0x80, then sel=011, ex_alu=0x300 while still stalled -> pending replaced. On release pc=0x300. Reverse order (EX pending first, then ID) -> pc=0x300 on release.
- Wrap and async reset: pc=0xFFFF_FFFC, sel=000 -> pc=0x0. Assert rst_n=0 mid-cycle with pending set -> pc=0x0 immediately, redirect_pending=0.
- With PC_MISALIGN_CHECK_EN: sel=001, ex_ta=0x103 -> pc=0x100, misalign_err=1 one cycle. Without the macro: pc=0x103, misalign_err=0.
